seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. Generalises the fixed 4-bit "1011" Moore detector to:
- any pattern up to PAT_W bits, with programmable length;
- overlap or non-overlap mode, selectable at run time;
- input-valid qualification;
- a saturating match counter.

It sits on a serial bit stream and flags each complete occurrence of the configured pattern with a registered (Moore) pulse.

Parameters:
- PAT_W, 4, maximum pattern length in bits (2..32).
- CNT_W, 8, width of the match counter.
- DEFAULT_PAT, 4'b1011 (PAT_W bits), pattern loaded at reset.
- DEFAULT_OVL, 1'b0, overlap mode loaded at reset (0 = non-overlap).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is sampled only on cycles where in_valid=1.
- in_bit  in  1  serial data bit.
- cfg_we  in  1  one-cycle strobe; loads cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  PAT_W  pattern, right-aligned. Bit [len-1] is the first bit expected on the line.
- cfg_len  in  LEN_W=$clog2(PAT_W+1)  active pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  registered one-cycle pulse per detected occurrence.
- match_cnt  out  CNT_W  saturating count of match pulses.
- fill  out  LEN_W  number of valid history bits currently held (debug/status).

Behaviour:
- Reset is synchronous and active-high.
  - On rst=1 at a clk edge: pat<=DEFAULT_PAT, len<=PAT_W, ovl<=DEFAULT_OVL, hist<=0, fill<=0, match<=0, match_cnt<=0.
  - rst overrides every other input, including mid-sequence: partial history is discarded.
- Config registers:
  - On cfg_we=1: pat, len and ovl load from the cfg_* ports; hist<=0, fill<=0, match<=0.
  - cfg_len=0 or cfg_len>PAT_W is stored as PAT_W.
  - cfg_we has priority over in_valid in the same cycle; that data bit is dropped.
- History: on in_valid=1 and cfg_we=0:
  - hist_n = {hist[PAT_W-2:0], in_bit};
  - fill_n = min(fill+1, PAT_W).
  - With in_valid=0, hist, fill and match_cnt hold, and match goes to 0.
- Match condition (combinational, on next values): hit = in_valid & ~cfg_we & (fill_n >= len) & (hist_n[len-1:0] == pat[len-1:0]).
- Moore output:
  - match <= hit, so match is high exactly one cycle, the cycle after the clock edge that accepted the final pattern bit.
  - match is never combinationally dependent on inputs.
- Mode:
  - On hit with ovl=0: fill<=0, hist<=0. The next match needs len fresh bits.
  - On hit with ovl=1: hist_n and fill_n are kept, so a suffix may start the next match.
- Counter:
  - On hit, match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets match_cnt<=0 and wins over a simultaneous hit; the match pulse itself is still produced.
- There is no explicit FSM encoding. Equivalent state is (fill, hist); fill counts 0..PAT_W. A back-to-back stream yields at most one match per accepted bit in overlap mode.

Decomposition:
- Package seq_det_pkg:
  - LEN_W calculation function;
  - DEFAULT_PAT and DEFAULT_OVL defaults;
  - a len-clamp function;
  - mask-by-length function mask(len) = (1<<len)-1, used for the compare.
- One sub-module: sat_counter (parameter W; ports clk, rst, clr, inc, q), instantiated for match_cnt.
- The history/compare logic stays inline.

Test Plan:
- Default config, non-overlap: stream 1,0,1,1,0,1,1 with in_valid=1 every cycle -> exactly one match pulse, in the cycle after bit 4; match_cnt=1; fill=3 at end.
- Same stream after cfg_we with cfg_pattern=4'b1011, len=4, overlap=1 -> match pulses after bits 4 and 7; match_cnt=2.
- Default config, same stream with in_valid=0 inserted between every bit -> identical match position, counted in accepted bits; match_cnt=1.
- cfg_pattern=2'b11, cfg_len=2, overlap=1, stream 1,1,1,1 -> matches after bits 2, 3 and 4. Same stream with cfg_len=0 -> clamped to 4: pattern 0011 never matches; match_cnt unchanged.
- CNT_W=2, overlap, pattern len=1 '1', stream of six 1s -> six match pulses; match_cnt saturates at 3. Then assert cnt_clr together with a seventh 1 -> match=1 and match_cnt=0.
- Feed 1,0,1 then assert rst for one cycle, then feed 1 -> no match; fill=1; match_cnt=0. Also apply cfg_we in the same cycle as a valid bit -> bit dropped and fill=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Width, length-clamp and compare-mask helpers are kept here so all users agree.
package seq_det_pkg;

   localparam logic [3:0] DEFAULT_PAT = 4'b1011;
   localparam logic       DEFAULT_OVL = 1'b0;

   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   // Zero or oversize lengths fall back to the full pattern width.
   function automatic int clamp_len(input int len, input int pat_w);
      return ((len == 0) || (len > pat_w)) ? pat_w : len;
   endfunction

   function automatic logic [31:0] mask(input int len);
      return (len >= 32) ? 32'hffff_ffff : ((32'd1 << len) - 32'd1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with a registered match pulse,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_prog #(
   parameter int             PAT_W       = 4,
   parameter int             CNT_W       = 8,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(seq_det_pkg::DEFAULT_PAT),
   parameter logic           DEFAULT_OVL = seq_det_pkg::DEFAULT_OVL,
   parameter int             LEN_W       = seq_det_pkg::len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [LEN_W-1:0] fill
);

   import seq_det_pkg::*;

   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [PAT_W-1:0] hist_q;
   logic [PAT_W-1:0] hist_n;
   logic [LEN_W-1:0] fill_n;
   logic [PAT_W-1:0] cmp_mask;
   logic             hit;

   always_comb begin
      hist_n   = {hist_q[PAT_W-2:0], in_bit};
      fill_n   = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
      cmp_mask = PAT_W'(mask(int'(len_q)));
      hit      = in_valid && !cfg_we && (fill_n >= len_q) &&
                 ((hist_n & cmp_mask) == (pat_q & cmp_mask));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= DEFAULT_PAT;
         len_q  <= LEN_W'(PAT_W);
         ovl_q  <= DEFAULT_OVL;
         hist_q <= '0;
         fill   <= '0;
         match  <= 1'b0;
      end else if (cfg_we) begin
         pat_q  <= cfg_pattern;
         len_q  <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
         ovl_q  <= cfg_overlap;
         hist_q <= '0;
         fill   <= '0;
         match  <= 1'b0;
      end else if (in_valid) begin
         match <= hit;
         // Non-overlap restarts from empty so the next match needs len fresh bits.
         if (hit && !ovl_q) begin
            hist_q <= '0;
            fill   <= '0;
         end else begin
            hist_q <= hist_n;
            fill   <= fill_n;
         end
      end else begin
         match <= 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (hit),
      .q   (match_cnt)
   );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed and random checks of seq_detect_prog against a queue-based model of
// accepted bits, with a 2-bit counter so saturation is reachable.
module tb_seq_detect_prog;

   localparam int PAT_W = 4;
   localparam int CNT_W = 2;
   localparam int LEN_W = 3;
   localparam int CNT_MAX = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             cfg_we = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             cfg_overlap = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic [LEN_W-1:0] fill;

   seq_detect_prog #(
      .PAT_W(PAT_W), .CNT_W(CNT_W), .DEFAULT_PAT(4'b1011), .DEFAULT_OVL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .match(match), .match_cnt(match_cnt), .fill(fill)
   );

   always #5 clk = ~clk;

   // Reference model: the accepted bits since the last restart, newest last.
   bit         q_bits[$];
   logic [3:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt;
   bit         m_match;

   int total = 0;
   int passed = 0;
   int pulses = 0;

   task automatic check(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   function automatic void model_step();
      bit hit;
      hit = 1'b0;
      if (rst) begin
         m_pat = 4'b1011; m_len = PAT_W; m_ovl = 1'b0;
         q_bits.delete(); m_match = 1'b0; m_cnt = 0;
         return;
      end
      if (cfg_we) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
         m_ovl = cfg_overlap;
         q_bits.delete();
         m_match = 1'b0;
      end else if (in_valid) begin
         q_bits.push_back(in_bit);
         if (q_bits.size() > PAT_W) void'(q_bits.pop_front());
         if (q_bits.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (q_bits[q_bits.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
         end
         m_match = hit;
         if (hit && !m_ovl) q_bits.delete();
      end else begin
         m_match = 1'b0;
      end
      if (cnt_clr) m_cnt = 0;
      else if (hit) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
   endfunction

   // One clock: inputs already set; update model at the edge, compare 1 ns later.
   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check({tag, ".match"}, int'(match), int'(m_match));
      check({tag, ".cnt"}, int'(match_cnt), m_cnt);
      check({tag, ".fill"}, int'(fill), (q_bits.size() > PAT_W) ? PAT_W : q_bits.size());
      if (match) pulses++;
      rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic feed(input string tag, input logic [31:0] bits, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         in_valid = 1'b1; in_bit = bits[i];
         step(tag);
         if (gaps) step(tag);
      end
   endtask

   task automatic configure(input logic [3:0] p, input logic [2:0] l, input bit o);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      step("cfg");
   endtask

   initial begin
      rst = 1'b1; step("reset");
      check("reset.cnt_const", int'(match_cnt), 0);
      check("reset.fill_const", int'(fill), 0);

      // Default pattern 1011, non-overlap.
      pulses = 0;
      feed("dflt", 32'b1011011, 7, 1'b0);
      check("dflt.pulses", pulses, 1);
      check("dflt.cnt_const", int'(match_cnt), 1);
      check("dflt.fill_const", int'(fill), 3);

      // Same pattern, overlap enabled.
      cnt_clr = 1'b1; step("clr");
      configure(4'b1011, 3'd4, 1'b1);
      pulses = 0;
      feed("ovl", 32'b1011011, 7, 1'b0);
      check("ovl.pulses", pulses, 2);
      check("ovl.cnt_const", int'(match_cnt), 2);

      // Default config with idle cycles between bits.
      rst = 1'b1; step("reset2");
      pulses = 0;
      feed("gaps", 32'b1011011, 7, 1'b1);
      check("gaps.pulses", pulses, 1);
      check("gaps.cnt_const", int'(match_cnt), 1);

      // Two-bit pattern 11 with overlap, then length 0 clamps to 4 (0011).
      cnt_clr = 1'b1; step("clr");
      configure(4'b0011, 3'd2, 1'b1);
      pulses = 0;
      feed("len2", 32'b1111, 4, 1'b0);
      check("len2.pulses", pulses, 3);
      configure(4'b0011, 3'd0, 1'b1);
      pulses = 0;
      feed("len0", 32'b1111, 4, 1'b0);
      check("len0.pulses", pulses, 0);
      check("len0.cnt_const", int'(match_cnt), 3);

      // Single-bit pattern: saturation, then clear racing a hit.
      configure(4'b0001, 3'd1, 1'b1);
      cnt_clr = 1'b1; step("clr");
      pulses = 0;
      feed("sat", 32'b111111, 6, 1'b0);
      check("sat.pulses", pulses, 6);
      check("sat.cnt_const", int'(match_cnt), 3);
      cnt_clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1; step("clrhit");
      check("clrhit.match_const", int'(match), 1);
      check("clrhit.cnt_const", int'(match_cnt), 0);

      // Reset mid-sequence discards history; config write drops a valid bit.
      rst = 1'b1; step("reset3");
      feed("pre", 32'b101, 3, 1'b0);
      rst = 1'b1; step("rstmid");
      feed("post", 32'b1, 1, 1'b0);
      check("post.match_const", int'(match), 0);
      check("post.fill_const", int'(fill), 1);
      check("post.cnt_const", int'(match_cnt), 0);
      cfg_we = 1'b1; cfg_pattern = 4'b0001; cfg_len = 3'd1; cfg_overlap = 1'b1;
      in_valid = 1'b1; in_bit = 1'b1; step("cfgdrop");
      check("cfgdrop.fill_const", int'(fill), 0);
      check("cfgdrop.match_const", int'(match), 0);

      // Random traffic with occasional reset, reconfiguration and clear.
      for (int n = 0; n < 600; n++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_bit      = 1'($urandom);
         rst         = ($urandom_range(0, 99) == 0);
         cfg_we      = ($urandom_range(0, 39) == 0);
         cfg_pattern = 4'($urandom);
         cfg_len     = 3'($urandom);
         cfg_overlap = 1'($urandom);
         cnt_clr     = ($urandom_range(0, 29) == 0);
         step("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
